// File: rtl/bcd_lap_hold_pkg.sv
// Shared constants for the lap-hold display path: state encoding, digit width,
// blank code and the board clock frequency.
package bcd_lap_hold_pkg;

    localparam int DIGIT_W     = 4;
    localparam int CLK_FREQ_HZ = 50_000_000;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } lap_state_e;

endpackage

// File: rtl/bcd_lap_hold_key_debounce.sv
// Two-flop synchroniser plus counting debouncer for an active-low push-button;
// emits a one-cycle registered pulse when the debounced level falls (press).
module key_debounce
    import bcd_lap_hold_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d    = s2_q;
            cnt_d   = '0;
            // Only the falling debounced edge is an event; releases are silent.
            press_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= key_n_i;
            s2_q    <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/bcd_lap_hold.sv
// Live/lap selector between the 3-digit BCD counter and the 7-segment decoders.
// Optional leading-zero blanking is enabled with LEADING_ZERO_BLANK_EN.
module bcd_lap_hold
    import bcd_lap_hold_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] live_bcd0,
    input  logic [DIGIT_W-1:0] live_bcd1,
    input  logic [DIGIT_W-1:0] live_bcd2,
    input  logic               lap_key_n,
    output logic [DIGIT_W-1:0] disp_bcd0,
    output logic [DIGIT_W-1:0] disp_bcd1,
    output logic [DIGIT_W-1:0] disp_bcd2,
    output logic               lap_active,
    output logic               lap_press
);

    lap_state_e         state_q, state_d;
    logic [DIGIT_W-1:0] hold0_q, hold1_q, hold2_q;
    logic [DIGIT_W-1:0] hold0_d, hold1_d, hold2_d;
    logic [DIGIT_W-1:0] disp0_q, disp1_q, disp2_q;
    logic [DIGIT_W-1:0] disp0_d, disp1_d, disp2_d;
    logic               active_q, active_d;
    logic               press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clock  (clock),
        .reset  (reset),
        .key_n_i(lap_key_n),
        .press_o(press)
    );

    always_comb begin
        state_d  = state_q;
        hold0_d  = hold0_q;
        hold1_d  = hold1_q;
        hold2_d  = hold2_q;
        disp0_d  = live_bcd0;
        disp1_d  = live_bcd1;
        disp2_d  = live_bcd2;
        active_d = active_q;
        case (state_q)
            LIVE: begin
                if (press) begin
                    hold0_d  = live_bcd0;
                    hold1_d  = live_bcd1;
                    hold2_d  = live_bcd2;
                    active_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (press) begin
                    active_d = 1'b0;
                    state_d  = LIVE;
                end else begin
                    disp0_d = hold0_q;
                    disp1_d = hold1_q;
                    disp2_d = hold2_q;
                end
            end
            default: state_d = LIVE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= LIVE;
            hold0_q  <= '0;
            hold1_q  <= '0;
            hold2_q  <= '0;
            disp0_q  <= '0;
            disp1_q  <= '0;
            disp2_q  <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold0_q  <= hold0_d;
            hold1_q  <= hold1_d;
            hold2_q  <= hold2_d;
            disp0_q  <= disp0_d;
            disp1_q  <= disp1_d;
            disp2_q  <= disp2_d;
            active_q <= active_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blanking sits after the display registers so it adds no latency.
    logic blank2;
    assign blank2    = (disp2_q == '0);
    assign disp_bcd2 = blank2 ? BLANK_CODE : disp2_q;
    assign disp_bcd1 = (blank2 && disp1_q == '0) ? BLANK_CODE : disp1_q;
`else
    assign disp_bcd2 = disp2_q;
    assign disp_bcd1 = disp1_q;
`endif
    assign disp_bcd0  = disp0_q;
    assign lap_active = active_q;
    assign lap_press  = press;

endmodule

// File: tb/tb_bcd_lap_hold.sv
// Directed bench for bcd_lap_hold with a 4-cycle debounce; expectations follow
// LEADING_ZERO_BLANK_EN when the bench is built with it defined.
module tb_bcd_lap_hold;

    logic       clock;
    logic       reset;
    logic [3:0] live_bcd0, live_bcd1, live_bcd2;
    logic       lap_key_n;
    logic [3:0] disp_bcd0, disp_bcd1, disp_bcd2;
    logic       lap_active;
    logic       lap_press;

    int n_checks;
    int n_fail;
    int press_cnt;

    bcd_lap_hold #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .live_bcd0 (live_bcd0),
        .live_bcd1 (live_bcd1),
        .live_bcd2 (live_bcd2),
        .lap_key_n (lap_key_n),
        .disp_bcd0 (disp_bcd0),
        .disp_bcd1 (disp_bcd1),
        .disp_bcd2 (disp_bcd2),
        .lap_active(lap_active),
        .lap_press (lap_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [11:0] exp_disp(input logic [3:0] d2, input logic [3:0] d1,
                                             input logic [3:0] d0);
        logic [3:0] e2, e1;
        e2 = d2;
        e1 = d1;
`ifdef LEADING_ZERO_BLANK_EN
        if (d2 == 4'h0) begin
            e2 = 4'hF;
            if (d1 == 4'h0) e1 = 4'hF;
        end
`endif
        return {e2, e1, d0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_live(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        live_bcd2 = d2;
        live_bcd1 = d1;
        live_bcd0 = d0;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0);
        check(tag, {disp_bcd2, disp_bcd1, disp_bcd0}, exp_disp(d2, d1, d0));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        press_cnt = 0;
        reset     = 1'b0;
        lap_key_n = 1'b1;
        set_live(4'd0, 4'd0, 4'd0);

        // Reset state
        step(2);
        chk_disp("reset_disp", 4'd0, 4'd0, 4'd0);
        check("reset_active", lap_active, 0);
        check("reset_press", lap_press, 0);
        reset = 1'b1;

        // Pass-through with one-cycle latency
        set_live(4'd1, 4'd2, 4'd3);
        step(1);
        chk_disp("live_123", 4'd1, 4'd2, 4'd3);
        check("live_123_active", lap_active, 0);
        check("live_123_press", lap_press, 0);

        // Bounce: low 3, high 1, low 2, then high; never reaches 4 stable cycles
        for (int i = 0; i < 18; i++) begin
            lap_key_n = (i < 3) ? 1'b0 : (i == 3) ? 1'b1 : (i < 6) ? 1'b0 : 1'b1;
            set_live(4'd0, 4'(i / 10), 4'(i % 10));
            step(1);
            chk_disp("bounce_disp", 4'd0, 4'(i / 10), 4'(i % 10));
            check("bounce_press", lap_press, 0);
            check("bounce_active", lap_active, 0);
        end

        // Clean press: pulse after edge 6, freeze after edge 7
        set_live(4'd0, 4'd4, 4'd5);
        lap_key_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("press_wait", lap_press, 0);
            check("press_wait_active", lap_active, 0);
            chk_disp("press_wait_disp", 4'd0, 4'd4, 4'd5);
        end
        step(1);
        check("press_pulse", lap_press, 1);
        check("press_pulse_active", lap_active, 0);
        step(1);
        check("hold_active", lap_active, 1);
        check("hold_press_low", lap_press, 0);
        chk_disp("hold_disp", 4'd0, 4'd4, 4'd5);
        set_live(4'd0, 4'd4, 4'd6);
        step(1);
        chk_disp("hold_ignores_046", 4'd0, 4'd4, 4'd5);
        set_live(4'd0, 4'd5, 4'd0);
        step(1);
        chk_disp("hold_ignores_050", 4'd0, 4'd4, 4'd5);
        check("hold_active_050", lap_active, 1);

        // Release produces no event
        lap_key_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("release_press", lap_press, 0);
            check("release_active", lap_active, 1);
            chk_disp("release_disp", 4'd0, 4'd4, 4'd5);
        end

        // Second press returns to live; 56 held cycles give one pulse
        set_live(4'd1, 4'd2, 4'd9);
        lap_key_n = 1'b0;
        for (int i = 1; i <= 56; i++) begin
            step(1);
            if (lap_press) press_cnt++;
            if (i == 6) begin
                check("press2_pulse", lap_press, 1);
                check("press2_still_hold", lap_active, 1);
                chk_disp("press2_still_frozen", 4'd0, 4'd4, 4'd5);
            end
            if (i == 7) begin
                check("press2_active", lap_active, 0);
                check("press2_pulse_end", lap_press, 0);
                chk_disp("press2_live", 4'd1, 4'd2, 4'd9);
            end
        end
        check("held_single_press", 12'(press_cnt), 12'd1);
        check("held_active", lap_active, 0);
        chk_disp("held_disp", 4'd1, 4'd2, 4'd9);

        // Re-enter HOLD at 0,4,5
        lap_key_n = 1'b1;
        step(10);
        set_live(4'd0, 4'd4, 4'd5);
        lap_key_n = 1'b0;
        step(7);
        check("rehold_active", lap_active, 1);
        chk_disp("rehold_disp", 4'd0, 4'd4, 4'd5);
        set_live(4'd0, 4'd8, 4'd8);
        step(1);
        chk_disp("rehold_frozen", 4'd0, 4'd4, 4'd5);

        // Reset in HOLD with key still held
        reset = 1'b0;
        step(1);
        chk_disp("midreset_disp", 4'd0, 4'd0, 4'd0);
        check("midreset_active", lap_active, 0);
        check("midreset_press", lap_press, 0);
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            check("post_reset_press", lap_press, (i == 6) ? 12'd1 : 12'd0);
            check("post_reset_active", lap_active, 0);
            chk_disp("post_reset_disp", 4'd0, 4'd8, 4'd8);
        end
        step(1);
        check("post_reset_hold", lap_active, 1);
        chk_disp("post_reset_hold_disp", 4'd0, 4'd8, 4'd8);

        // Leading-zero handling and raw code pass-through in LIVE
        lap_key_n = 1'b1;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        set_live(4'd0, 4'd0, 4'd7);
        step(1);
        chk_disp("lz_007", 4'd0, 4'd0, 4'd7);
        set_live(4'd0, 4'd3, 4'd0);
        step(1);
        chk_disp("lz_030", 4'd0, 4'd3, 4'd0);
        set_live(4'd0, 4'd0, 4'd0);
        step(1);
        chk_disp("lz_000", 4'd0, 4'd0, 4'd0);
        set_live(4'd1, 4'd0, 4'd0);
        step(1);
        chk_disp("lz_100", 4'd1, 4'd0, 4'd0);
        set_live(4'hA, 4'hF, 4'hC);
        step(1);
        chk_disp("non_bcd", 4'hA, 4'hF, 4'hC);
        check("final_active", lap_active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
